// File: rtl/calc_pkg.sv
// Shared definitions for the calculator entry path: key codes, operator encodings,
// sequencer states and key classification helpers.
package calc_pkg;

  localparam logic [7:0] KEY_0   = 8'h30;
  localparam logic [7:0] KEY_ADD = 8'h2B;
  localparam logic [7:0] KEY_SUB = 8'h2D;
  localparam logic [7:0] KEY_MUL = 8'h2A;
  localparam logic [7:0] KEY_EQ  = 8'h3D;
  localparam logic [7:0] KEY_ESC = 8'h1B;
  localparam logic [7:0] KEY_C   = 8'h43;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;

  typedef enum logic [1:0] {StEnterA, StEnterB, StWait, StShow} calcState_t;

  typedef enum logic [2:0] {KeyNone, KeyDigit, KeyOp, KeyEq, KeyClr} keyClass_t;

  function automatic keyClass_t keyClass(input logic [7:0] code);
    keyClass_t cls;
    if (code >= KEY_0 && code <= KEY_0 + 8'd9) begin
      cls = KeyDigit;
    end else begin
      case (code)
        KEY_ADD, KEY_SUB, KEY_MUL: cls = KeyOp;
        KEY_EQ:                    cls = KeyEq;
        KEY_ESC, KEY_C:            cls = KeyClr;
        default:                   cls = KeyNone;
      endcase
    end
    return cls;
  endfunction

  function automatic logic [1:0] opOf(input logic [7:0] code);
    logic [1:0] op;
    case (code)
      KEY_SUB: op = OP_SUB;
      KEY_MUL: op = OP_MUL;
      default: op = OP_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/key_sync.sv
// Brings the keyboard code-valid strobe into the Clk domain and captures the key code
// on its rising edge, producing a one-cycle KeyStb.
module key_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       Clk,
  input  logic       ResetN,
  input  logic [7:0] ScanValue,
  input  logic       KbdCodeValid,
  output logic       KeyStb,
  output logic [7:0] KeyCode
);

  logic [SYNC_STAGES-1:0] syncQ;
  logic                   prevQ;
  logic                   rise;
  logic                   keyStbQ;
  logic [7:0]             keyRegQ;

  assign rise = syncQ[SYNC_STAGES-1] & ~prevQ;

  // ScanValue is held stable by the receiver, so sampling it on the detect cycle is safe.
  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      syncQ   <= '0;
      prevQ   <= 1'b0;
      keyStbQ <= 1'b0;
      keyRegQ <= '0;
    end else begin
      syncQ   <= {syncQ[SYNC_STAGES-2:0], KbdCodeValid};
      prevQ   <= syncQ[SYNC_STAGES-1];
      keyStbQ <= rise;
      if (rise) keyRegQ <= ScanValue;
    end
  end

  assign KeyStb  = keyStbQ;
  assign KeyCode = keyRegQ;

endmodule

// File: rtl/calc_entry_ctrl.sv
// Calculator keyboard-entry sequencer: assembles two BCD operands and an operator,
// runs a req/ack transaction with the arithmetic unit and selects the display value.
module calc_entry_ctrl
  import calc_pkg::*;
#(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                Clk,
  input  logic                ResetN,
  input  logic [7:0]          ScanValue,
  input  logic                KbdCodeValid,
  output logic [4*DIGITS-1:0] OpA,
  output logic [4*DIGITS-1:0] OpB,
  output logic [1:0]          OpCode,
  output logic                CalcReq,
  input  logic                CalcAck,
  input  logic [4*DIGITS-1:0] Result,
  input  logic                CalcErr,
  output logic [4*DIGITS-1:0] DisplayValue,
  output logic                Error,
  output logic                Busy
);

  localparam int unsigned W    = 4 * DIGITS;
  localparam int unsigned CntW = $clog2(DIGITS + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DIGITS);

  logic       keyStb;
  logic [7:0] keyCode;

  key_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) uKeySync (
    .Clk         (Clk),
    .ResetN      (ResetN),
    .ScanValue   (ScanValue),
    .KbdCodeValid(KbdCodeValid),
    .KeyStb      (keyStb),
    .KeyCode     (keyCode)
  );

  calcState_t      stateQ, stateD;
  logic [W-1:0]    opAQ, opAD, opBQ, opBD, resQ, resD;
  logic [CntW-1:0] cntAQ, cntAD, cntBQ, cntBD;
  logic [1:0]      opCodeQ, opCodeD;
  logic            errQ, errD;

  keyClass_t  keyCls;
  logic [3:0] digit;
  logic [1:0] keyOp;

  assign keyCls = keyClass(keyCode);
  assign digit  = keyCode[3:0];
  assign keyOp  = opOf(keyCode);

  always_ff @(posedge Clk) begin
    if (!ResetN) stateQ <= StEnterA;
    else         stateQ <= stateD;
  end

  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      opAQ    <= '0;
      opBQ    <= '0;
      resQ    <= '0;
      cntAQ   <= '0;
      cntBQ   <= '0;
      opCodeQ <= OP_ADD;
      errQ    <= 1'b0;
    end else begin
      opAQ    <= opAD;
      opBQ    <= opBD;
      resQ    <= resD;
      cntAQ   <= cntAD;
      cntBQ   <= cntBD;
      opCodeQ <= opCodeD;
      errQ    <= errD;
    end
  end

  always_comb begin
    stateD  = stateQ;
    opAD    = opAQ;
    opBD    = opBQ;
    resD    = resQ;
    cntAD   = cntAQ;
    cntBD   = cntBQ;
    opCodeD = opCodeQ;
    errD    = errQ;
    // Keys (CLR included) are deliberately dead while a calculation is outstanding.
    if (stateQ == StWait) begin
      if (CalcAck) begin
        resD   = Result;
        errD   = CalcErr;
        stateD = StShow;
      end
    end else if (keyStb && keyCls == KeyClr) begin
      opAD    = '0;
      opBD    = '0;
      resD    = '0;
      cntAD   = '0;
      cntBD   = '0;
      opCodeD = OP_ADD;
      errD    = 1'b0;
      stateD  = StEnterA;
    end else if (keyStb) begin
      unique case (stateQ)
        StEnterA: begin
          if (keyCls == KeyDigit && cntAQ != CntMax) begin
            opAD  = {opAQ[W-5:0], digit};
            cntAD = cntAQ + CntW'(1);
          end else if (keyCls == KeyOp && cntAQ != '0) begin
            opCodeD = keyOp;
            opBD    = '0;
            cntBD   = '0;
            stateD  = StEnterB;
          end
        end
        StEnterB: begin
          if (keyCls == KeyDigit && cntBQ != CntMax) begin
            opBD  = {opBQ[W-5:0], digit};
            cntBD = cntBQ + CntW'(1);
          end else if (keyCls == KeyOp) begin
            opCodeD = keyOp;
          end else if (keyCls == KeyEq && cntBQ != '0) begin
            stateD = StWait;
          end
        end
        StShow: begin
          if (keyCls == KeyDigit) begin
            opAD   = {{(W-4){1'b0}}, digit};
            cntAD  = CntW'(1);
            opBD   = '0;
            cntBD  = '0;
            errD   = 1'b0;
            stateD = StEnterA;
          end else if (keyCls == KeyOp && !errQ) begin
            // Chain: the previous result becomes a full-width operand A.
            opAD    = resQ;
            cntAD   = CntMax;
            opCodeD = keyOp;
            opBD    = '0;
            cntBD   = '0;
            stateD  = StEnterB;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    CalcReq      = (stateQ == StWait);
    Busy         = CalcReq;
    DisplayValue = opAQ;
    unique case (stateQ)
      StEnterA:         DisplayValue = opAQ;
      StEnterB, StWait: DisplayValue = (cntBQ == '0) ? opAQ : opBQ;
      StShow:           DisplayValue = resQ;
      default:          DisplayValue = opAQ;
    endcase
  end

  assign OpA    = opAQ;
  assign OpB    = opBQ;
  assign OpCode = opCodeQ;
  assign Error  = errQ;

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Scoreboard bench for calc_entry_ctrl: a digit-queue model predicts requests and
// settled output snapshots; negedge monitors compare them against the DUT.
module tb_calc_entry_ctrl;

  localparam int unsigned D  = 4;
  localparam int unsigned SS = 2;
  localparam int unsigned W  = 4 * D;

  logic         Clk = 1'b0;
  logic         ResetN = 1'b0;
  logic [7:0]   ScanValue = 8'h00;
  logic         KbdCodeValid = 1'b0;
  logic [W-1:0] OpA, OpB, DisplayValue;
  logic [1:0]   OpCode;
  logic         CalcReq, Error, Busy;
  logic         CalcAck = 1'b0;
  logic [W-1:0] Result = '0;
  logic         CalcErr = 1'b0;

  calc_entry_ctrl #(
    .DIGITS     (D),
    .SYNC_STAGES(SS)
  ) dut (
    .Clk         (Clk),
    .ResetN      (ResetN),
    .ScanValue   (ScanValue),
    .KbdCodeValid(KbdCodeValid),
    .OpA         (OpA),
    .OpB         (OpB),
    .OpCode      (OpCode),
    .CalcReq     (CalcReq),
    .CalcAck     (CalcAck),
    .Result      (Result),
    .CalcErr     (CalcErr),
    .DisplayValue(DisplayValue),
    .Error       (Error),
    .Busy        (Busy)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [W-1:0] a, b, disp;
    logic [1:0]   op;
    logic         err, busy;
  } snap_t;

  typedef struct {
    logic [W-1:0] a, b;
    logic [1:0]   op;
  } req_t;

  snap_t chkQ[$];
  req_t  reqQ[$];
  int compared = 0;
  int mismatched = 0;

  function automatic void cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Behavioural model: operands as digit lists, phase 0=A entry, 1=B entry, 2=waiting, 3=result.
  int           qA[$];
  int           qB[$];
  int           phase;
  logic [1:0]   mOp;
  logic [W-1:0] mRes;
  logic         mErr;

  function automatic logic [W-1:0] packQ(input int q[$]);
    logic [W-1:0] v = '0;
    foreach (q[i]) v = (v << 4) | W'(q[i]);
    return v;
  endfunction

  function automatic void modelReset();
    qA.delete();
    qB.delete();
    phase = 0;
    mOp   = 2'd0;
    mRes  = '0;
    mErr  = 1'b0;
  endfunction

  function automatic snap_t expSnap();
    snap_t s;
    s.a    = packQ(qA);
    s.b    = packQ(qB);
    s.op   = mOp;
    s.err  = mErr;
    s.busy = (phase == 2);
    if (phase == 0)      s.disp = s.a;
    else if (phase == 3) s.disp = mRes;
    else                 s.disp = (qB.size() == 0) ? s.a : s.b;
    return s;
  endfunction

  function automatic void modelKey(input logic [7:0] code);
    bit isDigit = (code >= 8'h30 && code <= 8'h39);
    bit isOp    = (code == 8'h2B || code == 8'h2D || code == 8'h2A);
    logic [1:0] opv = (code == 8'h2D) ? 2'd1 : (code == 8'h2A) ? 2'd2 : 2'd0;
    req_t r;
    if (phase == 2) return;
    if (code == 8'h1B || code == 8'h43) begin
      modelReset();
    end else if (isDigit) begin
      if (phase == 0 && qA.size() < D) qA.push_back(int'(code) - 48);
      else if (phase == 1 && qB.size() < D) qB.push_back(int'(code) - 48);
      else if (phase == 3) begin
        qA.delete();
        qA.push_back(int'(code) - 48);
        qB.delete();
        mErr  = 1'b0;
        phase = 0;
      end
    end else if (isOp) begin
      if (phase == 0 && qA.size() > 0) begin
        mOp = opv;
        qB.delete();
        phase = 1;
      end else if (phase == 1) begin
        mOp = opv;
      end else if (phase == 3 && !mErr) begin
        qA.delete();
        for (int i = D - 1; i >= 0; i--) qA.push_back(int'(mRes[4*i+:4]));
        mOp = opv;
        qB.delete();
        phase = 1;
      end
    end else if (code == 8'h3D && phase == 1 && qB.size() > 0) begin
      phase = 2;
      r.a  = packQ(qA);
      r.b  = packQ(qB);
      r.op = mOp;
      reqQ.push_back(r);
    end
  endfunction

  // Monitors: settled snapshots, plus request contents held for the whole CalcReq phase.
  snap_t s;
  req_t  cur;
  bit    reqSeen = 1'b0;

  always @(negedge Clk) begin
    if (chkQ.size() > 0) begin
      s = chkQ.pop_front();
      cmp("OpA", 32'(OpA), 32'(s.a));
      cmp("OpB", 32'(OpB), 32'(s.b));
      cmp("OpCode", 32'(OpCode), 32'(s.op));
      cmp("DisplayValue", 32'(DisplayValue), 32'(s.disp));
      cmp("Error", 32'(Error), 32'(s.err));
      cmp("Busy", 32'(Busy), 32'(s.busy));
      cmp("CalcReq", 32'(CalcReq), 32'(s.busy));
    end
    if (CalcReq && !reqSeen) begin
      reqSeen = 1'b1;
      if (reqQ.size() == 0) begin
        cmp("unexpected CalcReq", 32'(CalcReq), 32'd0);
        cur.a  = OpA;
        cur.b  = OpB;
        cur.op = OpCode;
      end else begin
        cur = reqQ.pop_front();
      end
    end
    if (CalcReq) begin
      cmp("req OpA", 32'(OpA), 32'(cur.a));
      cmp("req OpB", 32'(OpB), 32'(cur.b));
      cmp("req OpCode", 32'(OpCode), 32'(cur.op));
    end else begin
      reqSeen = 1'b0;
    end
  end

  task automatic key(input logic [7:0] code, input int w = 1);
    modelKey(code);
    @(posedge Clk); #1;
    ScanValue    = code;
    KbdCodeValid = 1'b1;
    repeat (w) @(posedge Clk);
    #1 KbdCodeValid = 1'b0;
    repeat (SS + 3) @(posedge Clk);
    #1 chkQ.push_back(expSnap());
  endtask

  task automatic ack(input logic [W-1:0] res, input logic err, input int dly);
    int t = 0;
    while (!CalcReq && t < 20) begin
      @(posedge Clk); #1;
      t++;
    end
    if (!CalcReq) cmp("CalcReq before ack", 32'(CalcReq), 32'd1);
    repeat (dly) @(posedge Clk);
    #1;
    CalcAck = 1'b1;
    Result  = res;
    CalcErr = err;
    @(posedge Clk); #1;
    CalcAck = 1'b0;
    CalcErr = 1'b0;
    if (phase == 2) begin
      mRes  = res;
      mErr  = err;
      phase = 3;
    end
    chkQ.push_back(expSnap());
  endtask

  task automatic strayAck();
    @(posedge Clk); #1;
    CalcAck = 1'b1;
    Result  = 16'h9999;
    CalcErr = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    CalcAck = 1'b0;
    CalcErr = 1'b0;
    chkQ.push_back(expSnap());
  endtask

  task automatic pulseReset();
    @(posedge Clk); #1 ResetN = 1'b0;
    @(posedge Clk); #1;
    modelReset();
    chkQ.push_back(expSnap());
    @(negedge Clk); #1 ResetN = 1'b1;
  endtask

  task automatic stbTest(input int w);
    int first = -1;
    int cnt   = 0;
    @(posedge Clk); #1;
    ScanValue    = 8'h7F;
    KbdCodeValid = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      @(posedge Clk); #1;
      if (dut.keyStb) begin
        cnt++;
        if (first < 0) first = i;
      end
      if (i == w) KbdCodeValid = 1'b0;
    end
    cmp($sformatf("KeyStb latency w=%0d", w), 32'(first), 32'(SS + 1));
    cmp($sformatf("KeyStb count w=%0d", w), 32'(cnt), 32'd1);
  endtask

  function automatic logic [W-1:0] randBcd();
    logic [W-1:0] v;
    for (int i = 0; i < D; i++) v[4*i+:4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  function automatic logic [7:0] randKey();
    int r = $urandom_range(0, 9);
    logic [7:0] ops[3] = '{8'h2B, 8'h2D, 8'h2A};
    if (r <= 5) return 8'h30 + 8'($urandom_range(0, 9));
    if (r == 6) return ops[$urandom_range(0, 2)];
    if (r == 7) return 8'h3D;
    if (r == 8) return ($urandom_range(0, 2) == 0) ? 8'h1B : 8'h31;
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    modelReset();
    repeat (3) @(posedge Clk);
    #1 ResetN = 1'b1;
    chkQ.push_back(expSnap());

    key(8'h31); key(8'h32); key(8'h2B); key(8'h33); key(8'h3D);
    ack(16'h0015, 1'b0, 3);

    key(8'h2D); key(8'h34); key(8'h3D);
    key(8'h37); key(8'h1B); key(8'h7F);
    ack(16'h0099, 1'b1, 1);
    key(8'h2B);
    key(8'h43);

    key(8'h2A);
    for (int i = 1; i <= 5; i++) key(8'h30 + 8'(i));
    strayAck();

    key(8'h2B); key(8'h36); key(8'h3D);
    @(posedge Clk);
    pulseReset();

    stbTest(1);
    stbTest(5);

    for (int n = 0; n < 150; n++) begin
      if (phase == 2 && $urandom_range(0, 2) != 0)
        ack(randBcd(), ($urandom_range(0, 3) == 0), $urandom_range(0, 4));
      else
        key(randKey(), $urandom_range(1, 5));
    end

    repeat (4) @(posedge Clk);
    #1;
    cmp("pending requests", 32'(reqQ.size()), 32'd0);
    cmp("pending snapshots", 32'(chkQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/calc_entry_ctrl.md
# calc_entry_ctrl

Keyboard-entry sequencer for the calculator. Takes decoded key codes and the code-valid strobe from the PS/2 keyboard receiver and brings them into the system clock domain. It assembles two BCD operands and an operator, then issues a request/acknowledge transaction to the arithmetic unit. It also selects what the display shows: operand being typed, or last result.

## Interface
Parameters:
- DIGITS, 4, max BCD digits per operand; operand buses are 4*DIGITS bits wide
- SYNC_STAGES, 2, flip-flops in the KbdCodeValid synchronizer (min 2)

Ports:
- Clk  in  1  system clock; all logic on rising edge
- ResetN  in  1  synchronous, active-low reset
- ScanValue  in  8  decoded key code from the keyboard receiver (KeyClk domain, held stable until the next code)
- KbdCodeValid  in  1  receiver strobe (KeyClk domain); a rising edge marks a new code
- OpA  out  4*DIGITS  BCD operand A, LS digit in [3:0]
- OpB  out  4*DIGITS  BCD operand B
- OpCode  out  2  0=ADD, 1=SUB, 2=MUL (3 unused)
- CalcReq  out  1  request to the arithmetic unit
- CalcAck  in  1  arithmetic unit done; Result and CalcErr valid this cycle
- Result  in  4*DIGITS  BCD result
- CalcErr  in  1  result overflow/invalid, qualified by CalcAck
- DisplayValue  out  4*DIGITS  BCD value for the display driver
- Error  out  1  sticky error indicator
- Busy  out  1  high while CalcReq is high

## Operation
- Key strobe:
  - KbdCodeValid passes through SYNC_STAGES flops, then a rising-edge detector.
  - ScanValue is captured into KeyReg on the detect cycle, producing a one-cycle KeyStb.
- Key classes (ASCII):
  - 8'h30–8'h39 digit
  - 8'h2B '+' (ADD), 8'h2D '-' (SUB), 8'h2A '*' (MUL)
  - 8'h3D '=' (EQ)
  - 8'h1B or 8'h43 clear (CLR)
  - Any other code is ignored with no state change.
- Digit entry: `Op <= {Op[4*DIGITS-5:0], digit}` and the digit count increments. A digit arriving when the count is already DIGITS is dropped silently.
- States:
  - ENTER_A:
    - digit → shift into OpA.
    - operator with CntA≥1 → latch OpCode, clear OpB/CntB, go to ENTER_B.
    - operator with CntA=0 → ignored.
    - EQ → ignored.
  - ENTER_B:
    - digit → shift into OpB.
    - EQ with CntB≥1 → CalcReq<=1, go to WAIT.
    - EQ with CntB=0 → ignored.
    - operator → replaces OpCode, stays in ENTER_B.
  - WAIT:
    - All keys, including CLR, are ignored.
    - CalcAck → CalcReq<=0, ResReg<=Result, Error<=CalcErr, go to SHOW.
  - SHOW:
    - digit → clear OpA/OpB/Error, OpA<=digit, CntA=1, go to ENTER_A.
    - operator → chained calculation: OpA<=ResReg, CntA=DIGITS, latch OpCode, clear OpB, go to ENTER_B. Not allowed if Error=1; in that case the operator is ignored.
    - EQ → ignored.
- CLR in any state except WAIT: OpA/OpB/CntA/CntB/ResReg/Error cleared, OpCode=0, go to ENTER_A.
- DisplayValue:
  - ENTER_A → OpA
  - ENTER_B and WAIT → OpB, or OpA while CntB=0
  - SHOW → ResReg
- Reset values: all outputs 0; state ENTER_A; synchronizer, KeyReg and counters cleared.

## Timing
- KbdCodeValid rise → KeyStb is asserted SYNC_STAGES+1 Clk edges later. Registers and state update on the edge after KeyStb.
- CalcReq rises on the edge after the EQ KeyStb.
  - Held high until CalcAck is sampled high.
  - Falls on that same edge; SHOW is entered at that edge.
- OpA, OpB and OpCode are stable throughout CalcReq=1.
- CalcAck while CalcReq=0 is ignored.
- CalcAck already high on the cycle CalcReq rises is not accepted until the following edge.
- Busy == CalcReq combinationally from the state register.
- A new KbdCodeValid rising edge requires a low phase of at least SYNC_STAGES Clk cycles. The PS/2 frame period guarantees this at any Clk ≥ 1 MHz.
- ResetN low on any edge overrides everything, including a pending CalcReq (dropped on that edge).

## Structure
- Shared package calc_pkg holds:
  - key-code constants (KEY_ADD, KEY_SUB, KEY_MUL, KEY_EQ, KEY_ESC, KEY_C, KEY_0)
  - OpCode encodings
  - state encoding (ENTER_A, ENTER_B, WAIT, SHOW)
- One sub-module, key_sync: synchronizer, edge detect, and KeyReg capture. Outputs KeyStb and KeyCode.
- FSM, operand shift registers and display mux live in calc_entry_ctrl.

## Test plan
- Reset, then keys '1','2','+','3','=' → OpA=16'h0012, OpB=16'h0003, OpCode=0, CalcReq rises; bench acks 3 cycles later with Result=16'h0015 → CalcReq falls on ack edge, DisplayValue=16'h0015, Busy=0.
- Five digits '1'..'5' → OpA=16'h1234, 5th dropped; '*' with no digits after reset → ignored, state stays ENTER_A.
- In SHOW with Result=16'h0015: '-','4','=' → OpA=16'h0015, OpCode=1, OpB=16'h0004, CalcReq=1; CalcAck with CalcErr=1 → Error=1; a subsequent '+' is ignored; CLR → all zeros, Error=0.
- Keys pressed while in WAIT (including CLR) and an unknown code 8'h7F → no change; CalcAck with CalcReq=0 → ignored.
- ResetN low for one edge while CalcReq=1 → CalcReq=0, DisplayValue=0, state ENTER_A on that edge.
- KbdCodeValid pulses 1 Clk and 5 Clk wide → exactly one KeyStb each, arriving SYNC_STAGES+1 edges after the rise.
